// File: rtl/fft16_stage_ctrl_pkg.sv
// Shared types and constants for the 16-point radix-2 DIT FFT sequencer.
package fft16_stage_ctrl_pkg;

  localparam int unsigned N_POINTS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned TW_W     = 3;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned BF_LAT   = 2;
  localparam int unsigned WB_LAT   = RD_LAT + BF_LAT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_DRAIN,
    ST_UNLOAD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
  } wb_t;

  function automatic logic [ADDR_W-1:0] bitrev4(input logic [ADDR_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_stage_ctrl_addr_gen.sv
// Butterfly operand addressing: (stage, k) -> upper/lower operand address and twiddle index.
module fft16_stage_ctrl_addr_gen
  import fft16_stage_ctrl_pkg::*;
(
  input  logic [1:0]        stage_i,
  input  logic [2:0]        k_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [TW_W-1:0]   tw_idx_o
);

  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] pos_tw;

  always_comb begin
    k_ext    = {1'b0, k_i};
    span     = 4'd1 << stage_i;
    pos      = k_ext & (span - 4'd1);
    grp      = k_ext >> stage_i;
    // 3-bit shift amount so stage 3 does not wrap (stage+1 = 4)
    addr_a_o = (grp << ({1'b0, stage_i} + 3'd1)) | pos;
    addr_b_o = addr_a_o + span;
    pos_tw   = pos << (2'd3 - stage_i);
    tw_idx_o = pos_tw[TW_W-1:0];
  end

endmodule

// File: rtl/fft16_stage_ctrl.sv
// Sequencer for the 16-point FFT: bit-reversed load, 4 in-place butterfly stages, natural-order unload.
module fft16_stage_ctrl
  import fft16_stage_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ld_we,
  output logic [3:0] ld_addr,
  output logic       rd_en,
  output logic [3:0] rd_addr_a,
  output logic [3:0] rd_addr_b,
  output logic [2:0] tw_idx,
  output logic       wr_en,
  output logic [3:0] wr_addr_a,
  output logic [3:0] wr_addr_b,
  output logic [1:0] stage,
  output logic       out_rd,
  output logic [3:0] out_addr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  state_e            state_q;
  logic [3:0]        n_q;
  logic [2:0]        k_q;
  logic [1:0]        drain_q;
  logic [1:0]        stage_q;
  logic [4:0]        rd_cnt_q;
  logic [3:0]        hs_q;
  logic [3:0]        out_addr_q;
  logic              out_valid_q;
  wb_t               wb_q [WB_LAT];

  logic [ADDR_W-1:0] gen_a;
  logic [ADDR_W-1:0] gen_b;
  logic [TW_W-1:0]   gen_tw;
  logic              out_hs;

  fft16_stage_ctrl_addr_gen u_addr_gen (
    .stage_i  (stage_q),
    .k_i      (k_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign ld_we     = in_valid & in_ready;
  assign ld_addr   = bitrev4(n_q);
  assign rd_en     = (state_q == ST_CALC);
  assign rd_addr_a = rd_en ? gen_a  : '0;
  assign rd_addr_b = rd_en ? gen_b  : '0;
  assign tw_idx    = rd_en ? gen_tw : '0;
  assign wr_en     = wb_q[WB_LAT-1].en;
  assign wr_addr_a = wb_q[WB_LAT-1].a;
  assign wr_addr_b = wb_q[WB_LAT-1].b;
  assign stage     = stage_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // A new read is issued only when the output register is empty or being consumed.
  assign out_rd   = (state_q == ST_UNLOAD) && !rd_cnt_q[4] && (!out_valid_q || out_ready);
  assign out_hs   = out_valid_q && out_ready;
  // While stalled, out_addr keeps naming the sample currently on the bus.
  assign out_addr = out_rd ? rd_cnt_q[3:0] : out_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      stage_q     <= '0;
      rd_cnt_q    <= '0;
      hs_q        <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < WB_LAT; i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= '{en: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int unsigned i = 1; i < WB_LAT; i++) wb_q[i] <= wb_q[i-1];

      if (out_rd)         out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: if (start) state_q <= ST_LOAD;
        ST_LOAD: begin
          if (ld_we) begin
            if (n_q == 4'(N_POINTS - 1)) begin
              n_q     <= '0;
              state_q <= ST_CALC;
            end else begin
              n_q <= n_q + 4'd1;
            end
          end
        end
        ST_CALC: begin
          if (k_q == 3'd7) begin
            k_q     <= '0;
            state_q <= ST_DRAIN;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 2'(WB_LAT - 1)) begin
            drain_q <= '0;
            if (stage_q == 2'd3) begin
              stage_q <= '0;
              state_q <= ST_UNLOAD;
            end else begin
              stage_q <= stage_q + 2'd1;
              state_q <= ST_CALC;
            end
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_UNLOAD: begin
          if (out_rd) begin
            rd_cnt_q   <= rd_cnt_q + 5'd1;
            out_addr_q <= rd_cnt_q[3:0];
          end
          if (out_hs) begin
            if (hs_q == 4'(N_POINTS - 1)) begin
              hs_q       <= '0;
              rd_cnt_q   <= '0;
              out_addr_q <= '0;
              state_q    <= ST_DONE;
            end else begin
              hs_q <= hs_q + 4'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_stage_ctrl.sv
// Randomized self-checking bench for fft16_stage_ctrl against a schedule-level reference model.
module tb_fft16_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, ld_we, rd_en, wr_en, out_rd, out_valid, busy, done;
  logic [3:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
  logic [2:0] tw_idx;
  logic [1:0] stage;
  logic [36:0] outs;

  int total = 0;
  int bad   = 0;

  logic [3:0] ma [4][8];
  logic [3:0] mb [4][8];
  logic [2:0] mt [4][8];

  fft16_stage_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .out_rd    (out_rd),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  assign outs = {in_ready, ld_we, ld_addr, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en,
                 wr_addr_a, wr_addr_b, stage, out_rd, out_addr, out_valid, busy, done};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [3:0] bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) if (((v >> b) & 1) != 0) r += (1 << (3 - b));
    return 4'(r);
  endfunction

  // Butterfly schedule enumerated group by group, position within group.
  task automatic build_model();
    int span, ngrp, k;
    for (int s = 0; s < 4; s++) begin
      span = 1 << s;
      ngrp = 8 / span;
      for (int g = 0; g < ngrp; g++)
        for (int p = 0; p < span; p++) begin
          k = g * span + p;
          ma[s][k] = 4'(g * 2 * span + p);
          mb[s][k] = 4'(g * 2 * span + p + span);
          mt[s][k] = 3'(p * ngrp);
        end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  // Full frame; abort_t >= 0 applies an asynchronous reset at that CALC/DRAIN cycle.
  task automatic run_frame(input bit directed, input int abort_t);
    int n, gaps, cyc, s, j, tw, hold, issued, delivered, bus_addr;
    bit v, exp_rd, exp_wr, rdy, bus_full;
    logic [3:0] ld_tab [16];
    ld_tab = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
               4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
    n = 0; gaps = 0; cyc = 0; hold = 0; issued = 0; delivered = 0; bus_addr = 0;
    bus_full = 1'b0;

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_idle busy=%b want 0", busy); end

    while (n < 16 && cyc < 200) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      if (directed) begin
        v = !(n == 6 && gaps < 2);
        if (!v) gaps++;
      end else begin
        v = ($urandom_range(0, 3) != 0);
      end
      in_valid = v; out_ready = 1'($urandom_range(0, 1));
      #1; cyc++;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL load_ready n=%0d got=%b want 1", n, in_ready); end
      total++;
      if (ld_we !== v) begin bad++; $display("FAIL load_we n=%0d got=%b want %b", n, ld_we, v); end
      total++;
      if (ld_addr !== bitrev(n)) begin
        bad++; $display("FAIL load_addr n=%0d got=%0d want %0d", n, ld_addr, bitrev(n));
      end
      if (directed) begin
        total++;
        if (ld_addr !== ld_tab[n]) begin
          bad++; $display("FAIL load_table n=%0d got=%0d want %0d", n, ld_addr, ld_tab[n]);
        end
      end
      if (v) n++;
    end
    if (n < 16) begin
      total++; bad++; $display("FAIL load_timeout accepted=%0d want 16", n);
      return;
    end

    for (int t = 0; t < 44; t++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      s = t / 11; j = t % 11;
      exp_rd = (j < 8);
      tw = t - 3;
      exp_wr = (tw >= 0) && ((tw % 11) < 8);
      total++;
      if (in_ready !== 1'b0 || ld_we !== 1'b0) begin
        bad++; $display("FAIL calc_noload t=%0d in_ready=%b ld_we=%b want 0 0", t, in_ready, ld_we);
      end
      total++;
      if (rd_en !== exp_rd) begin bad++; $display("FAIL calc_rd_en t=%0d got=%b want %b", t, rd_en, exp_rd); end
      total++;
      if (stage !== 2'(s)) begin bad++; $display("FAIL calc_stage t=%0d got=%0d want %0d", t, stage, s); end
      if (exp_rd) begin
        total++;
        if (rd_addr_a !== ma[s][j] || rd_addr_b !== mb[s][j] || tw_idx !== mt[s][j]) begin
          bad++;
          $display("FAIL calc_addr s=%0d k=%0d got=(%0d,%0d,tw%0d) want (%0d,%0d,tw%0d)",
                   s, j, rd_addr_a, rd_addr_b, tw_idx, ma[s][j], mb[s][j], mt[s][j]);
        end
      end
      if (directed && ((s == 0 && j == 3) || (s == 1 && j == 5) || (s == 2 && j == 5) || (s == 3 && j == 7))) begin
        total++;
        case (s)
          0: exp_wr = exp_wr && (rd_addr_a === 4'd6) && (rd_addr_b === 4'd7)  && (tw_idx === 3'd0);
          1: exp_wr = exp_wr && (rd_addr_a === 4'd9) && (rd_addr_b === 4'd11) && (tw_idx === 3'd4);
          2: exp_wr = exp_wr && (rd_addr_a === 4'd9) && (rd_addr_b === 4'd13) && (tw_idx === 3'd2);
          default: exp_wr = exp_wr && (rd_addr_a === 4'd7) && (rd_addr_b === 4'd15) && (tw_idx === 3'd7);
        endcase
        if (!((s == 0 && rd_addr_a === 4'd6 && rd_addr_b === 4'd7 && tw_idx === 3'd0) ||
              (s == 1 && rd_addr_a === 4'd9 && rd_addr_b === 4'd11 && tw_idx === 3'd4) ||
              (s == 2 && rd_addr_a === 4'd9 && rd_addr_b === 4'd13 && tw_idx === 3'd2) ||
              (s == 3 && rd_addr_a === 4'd7 && rd_addr_b === 4'd15 && tw_idx === 3'd7))) begin
          bad++;
          $display("FAIL calc_known s=%0d k=%0d got=(%0d,%0d,tw%0d)", s, j, rd_addr_a, rd_addr_b, tw_idx);
        end
        exp_wr = (tw >= 0) && ((tw % 11) < 8);
      end
      total++;
      if (wr_en !== exp_wr) begin bad++; $display("FAIL wb_en t=%0d got=%b want %b", t, wr_en, exp_wr); end
      if (exp_wr) begin
        total++;
        if (wr_addr_a !== ma[tw / 11][tw % 11] || wr_addr_b !== mb[tw / 11][tw % 11]) begin
          bad++;
          $display("FAIL wb_addr t=%0d got=(%0d,%0d) want (%0d,%0d)", t, wr_addr_a, wr_addr_b,
                   ma[tw / 11][tw % 11], mb[tw / 11][tw % 11]);
        end
      end
      if (wr_en === 1'b1 && rd_en === 1'b1) begin
        total++;
        if (rd_addr_a === wr_addr_a || rd_addr_a === wr_addr_b ||
            rd_addr_b === wr_addr_a || rd_addr_b === wr_addr_b) begin
          bad++;
          $display("FAIL raw_hazard t=%0d rd=(%0d,%0d) wr=(%0d,%0d)", t, rd_addr_a, rd_addr_b,
                   wr_addr_a, wr_addr_b);
        end
      end
      total++;
      if (out_rd !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL calc_flags t=%0d out_rd=%b busy=%b want 0 1", t, out_rd, busy);
      end
      if (t == abort_t) begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL abort_async got=%h want=0", outs); end
        @(negedge clk); #1;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL abort_next got=%h want=0", outs); end
        rst_n = 1'b1;
        return;
      end
    end

    cyc = 0;
    while (delivered < 16 && cyc < 300) begin
      @(negedge clk);
      if (directed) begin
        rdy = 1'b1;
        if (bus_full && bus_addr == 6 && hold < 5) begin rdy = 1'b0; hold++; end
      end else begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      out_ready = rdy;
      in_valid = 1'($urandom_range(0, 1));
      start = (bus_full && rdy && delivered == 15) ? 1'b1 : 1'($urandom_range(0, 1));
      #1; cyc++;
      exp_rd = (issued < 16) && (!bus_full || rdy);
      total++;
      if (out_rd !== exp_rd) begin
        bad++; $display("FAIL unload_rd issued=%0d got=%b want %b", issued, out_rd, exp_rd);
      end
      if (exp_rd) begin
        total++;
        if (out_addr !== 4'(issued)) begin
          bad++; $display("FAIL unload_addr got=%0d want %0d", out_addr, issued);
        end
      end
      total++;
      if (out_valid !== bus_full) begin
        bad++; $display("FAIL unload_valid delivered=%0d got=%b want %b", delivered, out_valid, bus_full);
      end
      if (bus_full && !rdy) begin
        total++;
        if (out_addr !== 4'(bus_addr)) begin
          bad++; $display("FAIL unload_hold got=%0d want %0d", out_addr, bus_addr);
        end
      end
      total++;
      if (ld_we !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL unload_flags ld_we=%b rd_en=%b busy=%b done=%b want 0 0 1 0", ld_we, rd_en, busy, done);
      end
      if (bus_full && rdy) delivered++;
      if (exp_rd) begin
        bus_addr = issued; issued++; bus_full = 1'b1;
      end else if (rdy) begin
        bus_full = 1'b0;
      end
    end
    if (delivered < 16) begin
      total++; bad++; $display("FAIL unload_timeout delivered=%0d want 16", delivered);
      return;
    end

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL done_pulse done=%b busy=%b out_valid=%b want 1 1 0", done, busy, out_valid);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL back_idle done=%b busy=%b in_ready=%b want 0 0 0", done, busy, in_ready);
    end
  endtask

  task automatic test_directed_frame();
    run_frame(1'b1, -1);
  endtask

  task automatic test_reset_mid_calc();
    run_frame(1'b0, 25);
    run_frame(1'b1, -1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) run_frame(1'b0, -1);
  endtask

  initial begin
    build_model();
    test_reset();
    test_directed_frame();
    test_reset_mid_calc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
